// File: rtl/fetch_seq_pkg.sv
// Shared definitions for the instruction fetch sequencer: FSM states and
// opcode constants used by the sequencer and the decoder-side benches.
package fetch_seq_pkg;

  localparam int OP_W = 6;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH_OP = 3'd1,
    S_FETCH_C  = 3'd2,
    S_EXEC     = 3'd3,
    S_HALT     = 3'd4
  } state_t;

  localparam logic [OP_W-1:0] OP_HALT = 6'h3F;
  localparam logic [OP_W-1:0] OP_JMP  = 6'h30;
  localparam logic [OP_W-1:0] OP_JNZ  = 6'h31;
  localparam logic [OP_W-1:0] OP_JZ   = 6'h32;
  localparam logic [OP_W-1:0] OP_JR   = 6'h2C;

endpackage

// File: rtl/fetch_seq.sv
// Instruction fetch sequencer: fetches opcode and constant words over a
// req/ack handshake, holds them for EXEC, then applies the branch decision.
module fetch_seq
  import fetch_seq_pkg::*;
#(
  parameter int                 DATA_W   = 8,
  parameter int                 ADDR_W   = 8,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [OP_W-1:0]   op,
  output logic [DATA_W-1:0] c,
  output logic [ADDR_W-1:0] pc,
  output logic              exec_valid,
  input  logic              exec_busy,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  output logic              halted
);

  state_t            state;
  logic [OP_W-1:0]   op_reg;
  logic [ADDR_W-1:0] pc_inc;

  // Wraps modulo 2^ADDR_W, so a C word at the top address is followed by 0.
  assign pc_inc   = pc + ADDR_W'(1);
  // pc only moves on an ack, so the address is stable for the whole request.
  assign mem_addr = pc;

  // NOTE: all state and registered outputs use non-blocking assignments so
  // every branch below sees the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      pc         <= RESET_PC;
      op_reg     <= OP_HALT;
      op         <= OP_HALT;
      c          <= '0;
      mem_req    <= 1'b0;
      exec_valid <= 1'b0;
      halted     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (run) begin
            state   <= S_FETCH_OP;
            mem_req <= 1'b1;
          end
        end
        S_FETCH_OP: begin
          if (mem_ack) begin
            op_reg <= mem_rdata[DATA_W-1 -: OP_W];
            pc     <= pc_inc;
            state  <= S_FETCH_C;
          end
        end
        S_FETCH_C: begin
          if (mem_ack) begin
            c          <= mem_rdata;
            pc         <= pc_inc;
            state      <= S_EXEC;
            mem_req    <= 1'b0;
            exec_valid <= 1'b1;
            op         <= op_reg;
          end
        end
        S_EXEC: begin
          if (!exec_busy) begin
            if (br_taken) pc <= br_target;
            exec_valid <= 1'b0;
            op         <= OP_HALT;
            if (op_reg == OP_HALT) begin
              state  <= S_HALT;
              halted <= 1'b1;
            end else begin
              state   <= S_FETCH_OP;
              mem_req <= 1'b1;
            end
          end
        end
        S_HALT: begin
          state <= S_HALT;
        end
        default: begin
          state      <= S_IDLE;
          mem_req    <= 1'b0;
          exec_valid <= 1'b0;
          op         <= OP_HALT;
        end
      endcase
    end
  end

endmodule

// File: doc/fetch_seq.md
Name: fetch_seq

Overview:
- Instruction fetch sequencer directly upstream of the opcode decoder.
- Owns the PC and fetches each two-word instruction from program memory over a req/ack handshake: opcode word first, then constant word C.
- Presents OP and C to the decoder and datapath for one or more EXEC cycles.
- Applies the branch decision (br_taken plus target) at the end of EXEC.

Parameters:
- DATA_W, 8, program memory word width; must be >= 6.
- ADDR_W, 8, PC and memory address width.
- RESET_PC, 0, PC value after reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  level; starts fetching from IDLE.
- mem_req  out  1  program memory read request.
- mem_addr  out  ADDR_W  read address; stable while mem_req=1.
- mem_rdata  in  DATA_W  read data; valid in the mem_ack cycle.
- mem_ack  in  1  read completion, one cycle.
- op  out  6  opcode to decoder; 6'h3F (inert) outside EXEC.
- c  out  DATA_W  constant word C to datapath.
- pc  out  ADDR_W  current PC; during EXEC it is the address of the next sequential instruction.
- exec_valid  out  1  high in EXEC; datapath commits acc/PC only when high.
- exec_busy  in  1  datapath stall; holds EXEC while high.
- br_taken  in  1  from decoder, sampled in the final EXEC cycle.
- br_target  in  ADDR_W  datapath ALU result (pc+C or acc), low ADDR_W bits.
- halted  out  1  high in HALT.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, pc=RESET_PC, op register=6'h3F, c=0.
  - mem_req=0, mem_addr=RESET_PC, exec_valid=0, halted=0.
  - Reset mid-handshake abandons the access. Late acks are ignored because mem_req=0.
- States: IDLE, FETCH_OP, FETCH_C, EXEC, HALT. Binary encoding.
- IDLE: mem_req=0. run=1 moves to FETCH_OP next cycle.
- FETCH_OP:
  - mem_req=1, mem_addr=pc.
  - On mem_ack: op_reg <= mem_rdata[DATA_W-1 -: 6], pc <= pc+1, go to FETCH_C.
  - An ack in the first req cycle is legal (zero wait states).
  - Low DATA_W-6 bits of the opcode word are ignored.
- FETCH_C:
  - mem_req=1, mem_addr=pc.
  - On mem_ack: c <= mem_rdata, pc <= pc+1, go to EXEC.
  - mem_req drops for at least the EXEC cycle; there is no back-to-back req across instructions.
- EXEC:
  - op output = op_reg, exec_valid=1.
  - exec_busy=1 holds EXEC with outputs unchanged.
  - On the cycle exec_busy=0:
    - If br_taken=1, pc <= br_target; otherwise pc is unchanged.
    - If op_reg=6'h3F, go to HALT; otherwise go to FETCH_OP.
  - Minimum EXEC length is 1 cycle.
- HALT: halted=1, mem_req=0, op=6'h3F. Exits only on reset; run is ignored.
- Latency per instruction: 2 + wait states for opcode + wait states for C + 1 + busy cycles. Zero-wait minimum is 3 cycles.
- PC arithmetic wraps modulo 2^ADDR_W. The C word at address 2^ADDR_W-1 wraps to 0.
- Outside EXEC, op is forced to 6'h3F so the decoder's acc_update and br_taken are 0.
- run deasserting mid-instruction has no effect; it is sampled only in IDLE.
- mem_ack while mem_req=0 is ignored.

Decomposition:
- Shared package/header (alongside the existing signal include) holds:
  - state encodings;
  - OP_HALT=6'h3F;
  - OP width 6;
  - any opcode constants (JMP 6'h30, JZ 6'h32, JNZ 6'h31, JR 6'h2C) needed by benches.
- Single flat module; no sub-module. The PC incrementer stays inline.

Test Plan:
- Reset and idle: hold rst_n=0 then release with run=0 → pc=0, mem_req=0, op=6'h3F, exec_valid=0 for 10 cycles.
- Straight-line fetch, zero wait: memory [0]=0x08 (op 000010), [1]=0x05, run=1 → mem_addr 0 then 1, EXEC with op=6'h02, c=0x05, pc=2, then mem_addr=2.
- Wait states and busy: ack after 3 cycles on each word, exec_busy=1 for 2 cycles → exec_valid held 3 cycles, op/c stable, next fetch at pc=2.
- Taken branch: JMP at address 4, br_taken=1, br_target=0x20 → next mem_addr=0x20. JZ with br_taken=0 → next mem_addr=6.
- Halt: opcode word 0xFC at address 2 → one EXEC cycle with op=6'h3F, then halted=1, mem_req=0 indefinitely despite run toggling.
- Async reset mid FETCH_C (mem_req=1, no ack) → outputs take reset values immediately. An ack arriving after reset is ignored. After run=1, fetch restarts at 0.
- Wrap: RESET_PC=8'hFE, op at 0xFE and C at 0xFF → next fetch at 0x00.
